// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer: multi-precision adder reusing one 4-bit ripple-carry slice, LSB nibble first
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] sum,
  output logic [3:0] carry
);
  // each bit's carry-out is derived from its own prefix sum so the vector has no self-dependency
  for (genvar k = 0; k < 4; k++) begin : g_c
    logic [k+1:0] w_t;
    assign w_t      = {1'b0, a[k:0]} + {1'b0, b[k:0]} + (k+2)'(c);
    assign carry[k] = w_t[k+1];
  end
  assign sum = a ^ b ^ {carry[2:0], c};
endmodule

module rca_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NNIB = WIDTH / 4;
  localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_acc, w_acc_next;
  logic [IW-1:0]    r_idx;
  logic             r_carry, w_last;
  logic [3:0]       w_sum, w_carry;
  ripple_carry_adder u_slice (
    .a     (r_a[4*r_idx +: 4]),
    .b     (r_b[4*r_idx +: 4]),
    .c     (r_carry),
    .sum   (w_sum),
    .carry (w_carry)
  );
  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign w_last = (r_idx == IW'(NNIB - 1));
  // accumulator with the current nibble merged in, so the final edge can publish the full result
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[4*r_idx +: 4] = w_sum;
  end
  // control FSM and datapath registers; start is only honoured outside RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (r_state != S_RUN) begin
      r_state <= start ? S_RUN : S_IDLE;
      if (start) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
      end
    end else begin
      r_acc   <= w_acc_next;
      r_carry <= w_carry[3];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_state <= S_DONE;
        sum     <= w_acc_next;
        cout    <= w_carry[3];
        ovf     <= w_carry[3] ^ w_carry[2];
      end
    end
  end
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// tb_rca_nibble_sequencer: directed scoreboard bench for the 16-bit nibble sequencer
module tb_rca_nibble_sequencer;
  typedef struct { logic [15:0] s; logic c; logic v; } exp_t;
  logic        clk = 0, rst = 1, start = 0, cin = 0;
  logic [15:0] a = 0, b = 0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  exp_t        q[$];
  logic [15:0] last_sum = 0;
  int          passes = 0, total = 0;

  rca_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    e.s = t[15:0];
    e.c = t[16];
    e.v = (x[15] == y[15]) && (t[15] != x[15]);
    q.push_back(e);
    a = x; b = y; cin = ci; start = 1;
  endtask

  task automatic wait_done(input string tag, input bit hold, input int inject);
    int  n = 0, nb = 0;
    bit  seen = 0;
    exp_t e;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1 && !hold) start = 0;
      if (inject != 0 && n == inject) begin start = 1; a = 16'hAAAA; end
      if (inject != 0 && n == inject + 1) start = 0;
      if (n == 3) check({tag, "_sum_stable"}, sum, last_sum);
      if (done) seen = 1; else if (busy) nb++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, 5);
    check({tag, "_busy_cycles"}, nb, 4);
    check({tag, "_sb_nonempty"}, q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_sum"}, sum, e.s);
      check({tag, "_cout"}, cout, e.c);
      check({tag, "_ovf"}, ovf, e.v);
      last_sum = e.s;
    end
    if (!hold) begin
      @(negedge clk);
      check({tag, "_done_1cyc"}, done, 0);
    end
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 0;
    @(negedge clk);
    start_op(16'h1234, 16'h0FFF, 0); wait_done("t1", 0, 0);
    start_op(16'hFFFF, 16'h0001, 0); wait_done("t2a", 0, 0);
    start_op(16'hFFFF, 16'h0000, 1); wait_done("t2b", 0, 0);
    start_op(16'h7FFF, 16'h0001, 0); wait_done("t3a", 0, 0);
    start_op(16'h8000, 16'h8000, 0); wait_done("t3b", 0, 0);
    start_op(16'h1111, 16'h2222, 0); wait_done("t4", 0, 2);
    a = 16'h0101; b = 16'h0202; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum", sum, 0);
    check("t5_cout", cout, 0);
    check("t5_ovf", ovf, 0);
    last_sum = 0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("t5_no_done", pulses, 0);
    start_op(16'h00F0, 16'h0F00, 0); wait_done("t6a", 1, 0);
    start_op(16'h0001, 16'h0002, 0); wait_done("t6b", 0, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
